// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: one frame per PERIOD_CNT clocks, high time MIN_CNT + code*STEP_CNT.
// Codes land in a shadow register and are only adopted at frame start, so pulses never glitch.
module servo_pwm_gen #(
    parameter int cant_bits  = 13,
    parameter int CNT_W      = 20,
    parameter int PERIOD_CNT = 1000000,
    parameter int MIN_CNT    = 50000,
    parameter int STEP_CNT   = 196,
    parameter int MAX_CODE   = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [cant_bits-1:0] dato,
    input  logic                 dato_valid,
    input  logic                 enable,
    output logic                 pwm_out,
    output logic                 frame_tick,
    output logic                 sat,
    output logic                 busy
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [cant_bits-1:0] MAX_C = cant_bits'(MAX_CODE);
    localparam logic [CNT_W-1:0]     LAST  = CNT_W'(PERIOD_CNT - 1);

    state_t               state;
    logic [CNT_W-1:0]     counter;
    logic [CNT_W-1:0]     counter_inc;
    logic [CNT_W-1:0]     width_reg;
    logic [CNT_W-1:0]     width_next;
    logic [cant_bits-1:0] pending_code;

    // pending_code is clamped to MAX_CODE, so the truncating cast cannot lose bits
    assign width_next  = CNT_W'(MIN_CNT) + CNT_W'(pending_code) * CNT_W'(STEP_CNT);
    assign counter_inc = counter + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            counter      <= '0;
            width_reg    <= '0;
            pending_code <= '0;
            pwm_out      <= 1'b0;
            frame_tick   <= 1'b0;
            sat          <= 1'b0;
            busy         <= 1'b0;
        end else begin
            frame_tick <= 1'b0;

            if (dato_valid) begin
                pending_code <= (dato > MAX_C) ? MAX_C : dato;
                sat          <= (dato > MAX_C);
            end

            case (state)
                IDLE: begin
                    pwm_out <= 1'b0;
                    busy    <= 1'b0;
                    if (enable) begin
                        state      <= RUN;
                        counter    <= '0;
                        width_reg  <= width_next;
                        pwm_out    <= 1'b1;
                        frame_tick <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                RUN: begin
                    if (counter == LAST) begin
                        // enable only matters here; a mid-frame drop still finishes the frame
                        if (enable) begin
                            counter    <= '0;
                            width_reg  <= width_next;
                            pwm_out    <= 1'b1;
                            frame_tick <= 1'b1;
                        end else begin
                            state   <= IDLE;
                            counter <= '0;
                            pwm_out <= 1'b0;
                            busy    <= 1'b0;
                        end
                    end else begin
                        counter <= counter_inc;
                        pwm_out <= (counter_inc < width_reg);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Bench for servo_pwm_gen: directed frame-width scenarios plus randomized run against a frame model.
module tb_servo_pwm_gen;

    localparam int CB = 13, CW = 8, PER = 100, MINC = 10, STEP = 1, MAXC = 50;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CB-1:0] dato = '0;
    logic          dato_valid = 1'b0;
    logic          enable = 1'b0;
    logic          pwm_out, frame_tick, sat, busy;

    int checks = 0;
    int failures = 0;

    servo_pwm_gen #(
        .cant_bits(CB), .CNT_W(CW), .PERIOD_CNT(PER),
        .MIN_CNT(MINC), .STEP_CNT(STEP), .MAX_CODE(MAXC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .dato(dato), .dato_valid(dato_valid),
        .enable(enable), .pwm_out(pwm_out), .frame_tick(frame_tick),
        .sat(sat), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // samples the current cycle then advances, n times
    task automatic measure(input int n, output int hi, output int ticks);
        hi = 0;
        ticks = 0;
        for (int i = 0; i < n; i++) begin
            hi    += int'(pwm_out);
            ticks += int'(frame_tick);
            step();
        end
    endtask

    task automatic wait_tick(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 2 * PER + 10 && !seen; i++) begin
            if (frame_tick) seen = 1'b1;
            else step();
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s: frame_tick not seen within bound", name);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        #3;
        checks++;
        if ({pwm_out, frame_tick, sat, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs: got %b want 0000", {pwm_out, frame_tick, sat, busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if ({pwm_out, frame_tick, busy} !== 3'b000) begin
            failures++;
            $display("FAIL idle_no_enable: got %b want 000", {pwm_out, frame_tick, busy});
        end
    endtask

    task automatic test_default_frames();
        int h, t;
        enable = 1'b1;
        step();
        checks++;
        if ({frame_tick, busy, pwm_out} !== 3'b111) begin
            failures++;
            $display("FAIL first_frame_start: got %b want 111", {frame_tick, busy, pwm_out});
        end
        for (int f = 0; f < 2; f++) begin
            measure(PER, h, t);
            checks++;
            if (h !== 10 || t !== 1) begin
                failures++;
                $display("FAIL default_frame%0d: high=%0d ticks=%0d want high=10 ticks=1", f, h, t);
            end
        end
    endtask

    task automatic test_mid_strobe();
        int h1, h2, h3, t;
        measure(50, h1, t);
        dato = 20;
        dato_valid = 1'b1;
        measure(1, h2, t);
        dato_valid = 1'b0;
        checks++;
        if (sat !== 1'b0) begin
            failures++;
            $display("FAIL strobe20_sat: got %b want 0", sat);
        end
        measure(49, h3, t);
        checks++;
        if (h1 + h2 + h3 !== 10) begin
            failures++;
            $display("FAIL strobe_current_frame: high=%0d want 10", h1 + h2 + h3);
        end
        measure(PER, h1, t);
        checks++;
        if (h1 !== 30 || t !== 1) begin
            failures++;
            $display("FAIL strobe_next_frame: high=%0d ticks=%0d want 30/1", h1, t);
        end
    endtask

    task automatic test_saturation();
        int h1, h2, h3, t;
        measure(20, h1, t);
        dato = 13'd300;
        dato_valid = 1'b1;
        measure(1, h2, t);
        dato_valid = 1'b0;
        checks++;
        if (sat !== 1'b1) begin
            failures++;
            $display("FAIL sat_flag: got %b want 1", sat);
        end
        measure(79, h3, t);
        checks++;
        if (h1 + h2 + h3 !== 30) begin
            failures++;
            $display("FAIL sat_current_frame: high=%0d want 30", h1 + h2 + h3);
        end
        measure(PER, h1, t);
        checks++;
        if (h1 !== 60) begin
            failures++;
            $display("FAIL sat_clamped_frame: high=%0d want 60", h1);
        end
    endtask

    task automatic test_boundary_strobe();
        int h1, h2, h3, h4, t;
        measure(30, h1, t);
        dato = 20;
        dato_valid = 1'b1;
        measure(1, h2, t);
        dato_valid = 1'b0;
        measure(68, h3, t);
        dato = 5;
        dato_valid = 1'b1;
        measure(1, h4, t);
        dato_valid = 1'b0;
        checks++;
        if (h1 + h2 + h3 + h4 !== 60 || frame_tick !== 1'b1) begin
            failures++;
            $display("FAIL boundary_prev_frame: high=%0d tick=%b want 60/1", h1 + h2 + h3 + h4, frame_tick);
        end
        measure(PER, h1, t);
        measure(PER, h2, t);
        checks++;
        if (h1 !== 30 || h2 !== 15) begin
            failures++;
            $display("FAIL boundary_order: frames %0d,%0d want 30,15", h1, h2);
        end
    endtask

    task automatic test_enable_drop();
        int h1, h2, t;
        measure(40, h1, t);
        enable = 1'b0;
        measure(60, h2, t);
        checks++;
        if (h1 + h2 !== 15) begin
            failures++;
            $display("FAIL drop_frame_complete: high=%0d want 15", h1 + h2);
        end
        checks++;
        if ({pwm_out, busy, frame_tick} !== 3'b000) begin
            failures++;
            $display("FAIL drop_idle: got %b want 000", {pwm_out, busy, frame_tick});
        end
        measure(30, h1, t);
        checks++;
        if (h1 !== 0 || t !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL drop_stays_idle: high=%0d ticks=%0d busy=%b want 0/0/0", h1, t, busy);
        end
        enable = 1'b1;
        step();
        checks++;
        if ({frame_tick, busy, pwm_out} !== 3'b111) begin
            failures++;
            $display("FAIL reenable_start: got %b want 111", {frame_tick, busy, pwm_out});
        end
    endtask

    task automatic test_reset_mid_pulse();
        int h, t;
        dato = 20;
        dato_valid = 1'b1;
        step();
        dato_valid = 1'b0;
        measure(98, h, t);
        step();
        checks++;
        if (frame_tick !== 1'b1) begin
            failures++;
            $display("FAIL rst_setup_tick: got %b want 1", frame_tick);
        end
        dato = 13'd300;
        dato_valid = 1'b1;
        step();
        dato_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if ({pwm_out, sat, busy} !== 3'b111) begin
            failures++;
            $display("FAIL rst_setup_state: got %b want 111", {pwm_out, sat, busy});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pwm_out, busy, sat, frame_tick} !== 4'b0000) begin
            failures++;
            $display("FAIL async_reset: got %b want 0000", {pwm_out, busy, sat, frame_tick});
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_tick("rst_restart");
        measure(PER, h, t);
        checks++;
        if (h !== 10 || sat !== 1'b0) begin
            failures++;
            $display("FAIL rst_first_frame: high=%0d sat=%b want 10/0", h, sat);
        end
    endtask

    task automatic test_random();
        bit run = 1'b0, msat = 1'b0;
        int age = 0, width = 0, pend = 0, old;
        logic [3:0] expv;
        rst_n = 1'b0;
        enable = 1'b0;
        dato_valid = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        enable = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            dato_valid = ($urandom_range(0, 24) == 0);
            dato = ($urandom_range(0, 3) == 0) ? CB'($urandom) : CB'($urandom_range(0, 60));
            // frame model: widths are fixed from the code held when a frame begins
            old = pend;
            if (dato_valid) begin
                pend = (int'(dato) > MAXC) ? MAXC : int'(dato);
                msat = (int'(dato) > MAXC);
            end
            if (run) begin
                age++;
                if (age == PER) begin
                    if (enable) begin
                        age = 0;
                        width = MINC + old * STEP;
                    end else run = 1'b0;
                end
            end else if (enable) begin
                run = 1'b1;
                age = 0;
                width = MINC + old * STEP;
            end
            step();
            expv = {run && age < width, run && age == 0, run, msat};
            checks++;
            if ({pwm_out, frame_tick, busy, sat} !== expv) begin
                failures++;
                $display("FAIL random_cycle%0d: pwm/tick/busy/sat=%b want %b", c, {pwm_out, frame_tick, busy, sat}, expv);
            end
        end
        dato_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default_frames();
        test_mid_strobe();
        test_saturation();
        test_boundary_strobe();
        test_enable_drop();
        test_reset_mid_pulse();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/servo_pwm_gen.md
Name: servo_pwm_gen

Overview:
- Downstream consumer of the 13-bit position code from the sample-conversion/concatenation stage; turns that code into the servo drive pulse.
- Emits one PWM frame per period; high time = MIN_CNT + code*STEP_CNT clock cycles.
- New codes are buffered in a shadow register and applied only at frame boundaries, so pulses are never glitched or truncated.

Parameters:
cant_bits, 13, width of input code (matches upstream output)
CNT_W, 20, frame counter width
PERIOD_CNT, 1000000, frame length in clk cycles (20 ms @ 50 MHz)
MIN_CNT, 50000, high time for code 0 (1 ms); must be >= 1
STEP_CNT, 196, high-time increment per code LSB
MAX_CODE, 255, saturation limit for the code; MIN_CNT + MAX_CODE*STEP_CNT < PERIOD_CNT required

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
dato  input  cant_bits  unsigned position code from upstream stage
dato_valid  input  1  one-cycle strobe: capture dato
enable  input  1  run request; sampled only at frame boundaries
pwm_out  output  1  servo pulse, registered
frame_tick  output  1  one-cycle pulse in first cycle of each frame
sat  output  1  registered; 1 when last captured code exceeded MAX_CODE
busy  output  1  1 while a frame is in progress (RUN state)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0, pending_code=0, pwm_out=0, frame_tick=0, sat=0, busy=0. Reset mid-frame aborts the pulse immediately; no frame resumes after release until enable sampled high.
- Capture: on a clk edge with dato_valid=1: pending_code <= min(dato, MAX_CODE); sat <= (dato > MAX_CODE). dato_valid may arrive any cycle; the last strobe before a boundary wins.
- Width calc: width = MIN_CNT + pending_code*STEP_CNT, unsigned, CNT_W bits, no overflow given parameter constraint.
- States: IDLE, RUN.
  - IDLE: pwm_out=0, busy=0. On edge with enable=1 -> RUN: counter<=0, width_reg<=width(pending_code), pwm_out<=1, frame_tick<=1, busy<=1. Call this edge frame start, cycle T0.
  - RUN: counter increments each cycle. pwm_out=1 for cycles T0..T0+width_reg-1, 0 for T0+width_reg..T0+PERIOD_CNT-1. frame_tick=1 only at T0.
  - Boundary (counter==PERIOD_CNT-1): if enable=1, new frame starts next edge (T0+PERIOD_CNT) with width_reg reloaded from pending_code; else -> IDLE, pwm_out=0, busy=0.
- enable deasserted mid-frame: current frame completes in full; no truncation.
- dato_valid on the boundary edge itself: new frame uses the pending_code value held before that edge; the new code applies to the following frame. Latency from strobe to pulse: 1 to PERIOD_CNT+1 cycles.
- No dato_valid ever received: frames use code 0 (MIN_CNT high time).
- width_reg stable for the whole frame regardless of input activity.

Test Plan (sim params: PERIOD_CNT=100, MIN_CNT=10, STEP_CNT=1, MAX_CODE=50, CNT_W=8):
- Reset then enable=1, no dato -> frame_tick every 100 cycles; pwm_out high exactly 10 cycles per frame; busy=1.
- dato=20 strobed mid-frame -> current frame stays 10 high; next frame 30 high; sat=0.
- dato=13'd300 strobed -> sat=1; following frame 60 high (clamped at 50).
- dato_valid with dato=5 coincident with boundary edge, prior pending=20 -> new frame 30 high, next frame 15 high.
- enable dropped at cycle 40 of a frame -> frame completes to cycle 99, then pwm_out=0, busy=0, no further frame_tick; re-enable -> frame_tick on the next edge.
- rst_n asserted at cycle 5 of a 30-cycle pulse -> pwm_out, busy, sat, frame_tick = 0 immediately (asynchronous); pending_code=0; after release with enable=1, first frame 10 high.
